// File: rtl/cfg_pkg.sv
// Shared configuration for the SI5340 I2C register responder: bus address,
// page-select register offset, protocol state encoding and R/W bit type.
package cfg_pkg;
  localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h74;
  localparam logic [7:0] PAGE_REG_OFFSET    = 8'h01;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  typedef enum logic {RW_WRITE = 1'b0, RW_READ = 1'b1} rw_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so everything resets to 1 to avoid a false START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= (scl_sync << 1) | SYNC_STAGES'(scl_in);
      sda_sync <= (sda_sync << 1) | SYNC_STAGES'(sda_in);
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign sda      = sda_s;
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
endmodule

// File: rtl/si5340_i2c_responder.sv
// I2C target emulating the SI5340 paged register map: {page, offset} addressing,
// auto-incrementing offset, page register at offset 0x01.
module si5340_i2c_responder
  import cfg_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic        wr_en_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o
);
  logic       sda, scl_rise, scl_fall, start, stop;
  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, page, offset, rx_byte, load_val;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_i), .rst(rst_i), .scl_in(scl_pad_i), .sda_in(sda_pad_i),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start(start), .stop(stop)
  );

  assign sda_pad_o = 1'b0;
  assign rd_addr_o = {page, offset};
  assign rx_byte   = {shreg[6:0], sda};
  assign load_val  = (offset == PAGE_REG_OFFSET) ? page : rd_data_i;

  // Bits are sampled on SCL rise; all SDA drive changes happen on SCL fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      page         <= '0;
      offset       <= '0;
      sda_padoen_o <= 1'b1;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      busy_o       <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        bit_cnt      <= '0;
        sda_padoen_o <= 1'b1;
        busy_o       <= 1'b0;
      end else if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          ADDR, REG, WDATA: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (state == WDATA && bit_cnt == 4'd7) begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= {page, offset};
              wr_data_o <= rx_byte;
              offset    <= offset + 8'd1;
              if (offset == PAGE_REG_OFFSET) page <= rx_byte;
            end
          end
          RDATA: bit_cnt <= bit_cnt + 4'd1;
          RDATA_ACK: if (sda) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              state        <= ADDR_ACK;
              sda_padoen_o <= 1'b0;
              busy_o       <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            sda_padoen_o <= 1'b1;
          end
          REG: if (bit_cnt == 4'd8) begin
            offset       <= shreg;
            bit_cnt      <= '0;
            state        <= REG_ACK;
            sda_padoen_o <= 1'b0;
          end
          WDATA: if (bit_cnt == 4'd8) begin
            bit_cnt      <= '0;
            state        <= WDATA_ACK;
            sda_padoen_o <= 1'b0;
          end
          ADDR_ACK: if (rw_t'(shreg[0]) == RW_READ) begin
            state        <= RDATA;
            shreg        <= load_val;
            sda_padoen_o <= load_val[7];
          end else begin
            state        <= REG;
            sda_padoen_o <= 1'b1;
          end
          REG_ACK, WDATA_ACK: begin
            state        <= WDATA;
            sda_padoen_o <= 1'b1;
          end
          RDATA: if (bit_cnt == 4'd8) begin
            bit_cnt      <= '0;
            state        <= RDATA_ACK;
            sda_padoen_o <= 1'b1;
            offset       <= offset + 8'd1;
          end else begin
            shreg        <= {shreg[6:0], 1'b0};
            sda_padoen_o <= shreg[6];
          end
          RDATA_ACK: begin
            state        <= RDATA;
            shreg        <= load_val;
            sda_padoen_o <= load_val[7];
          end
          default: ;
        endcase
      end
    end
  end
endmodule
